// File: rtl/mic1_exec_ctrl.sv
// +----------------------------------------------------------------------+
// | mic1_exec_ctrl : run/step/breakpoint execution controller for mic1   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module mic1_exec_ctrl #(
   parameter int STEP_W      = 8,
   parameter int CNT_W       = 32,
   parameter int CYCLE_LIMIT = 0
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              step,
   input  logic              stop,
   input  logic              clear,
   input  logic [STEP_W-1:0] step_count,
   input  logic              bp_en,
   input  logic [8:0]        bp_addr,
   input  logic [8:0]        mpc,
   input  logic              prog_halt,
   output logic              run,
   output logic              busy,
   output logic              done,
   output logic [2:0]        stop_reason,
   output logic [CNT_W-1:0]  cycle_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_STEP = 2'd2,
      S_HALT = 2'd3
   } state_t;

   localparam logic [2:0] R_NONE  = 3'd0;
   localparam logic [2:0] R_STOP  = 3'd1;
   localparam logic [2:0] R_STEP  = 3'd2;
   localparam logic [2:0] R_BP    = 3'd3;
   localparam logic [2:0] R_PROG  = 3'd4;
   localparam logic [2:0] R_LIMIT = 3'd5;

   localparam logic [CNT_W:0] LIMIT = (CNT_W+1)'(CYCLE_LIMIT);

   state_t            state;
   logic [STEP_W-1:0] remaining;
   logic              first;

   logic [CNT_W:0]    cnt_plus1;
   logic [CNT_W-1:0]  cnt_sat;
   logic [STEP_W-1:0] step_load;
   logic              bp_hit;
   logic              limit_hit;
   logic              step_last;

   always_comb begin
      cnt_plus1 = {1'b0, cycle_count} + {{CNT_W{1'b0}}, 1'b1};
      cnt_sat   = cnt_plus1[CNT_W] ? cycle_count : cnt_plus1[CNT_W-1:0];
      step_load = (step_count == '0) ? STEP_W'(1) : step_count;
      // The first busy cycle skips the breakpoint so a resume steps off it.
      bp_hit    = bp_en && (mpc == bp_addr) && !first;
      limit_hit = (CYCLE_LIMIT != 0) && (cnt_plus1 == LIMIT);
      step_last = (state == S_STEP) && (remaining == STEP_W'(1));
   end

   assign run  = (state == S_RUN) || (state == S_STEP);
   assign busy = run;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state       <= S_IDLE;
         remaining   <= '0;
         first       <= 1'b1;
         done        <= 1'b0;
         stop_reason <= R_NONE;
         cycle_count <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (clear) begin
                  cycle_count <= '0;
                  stop_reason <= R_NONE;
               end
               if (start) begin
                  state       <= S_RUN;
                  stop_reason <= R_NONE;
                  first       <= 1'b1;
               end else if (step) begin
                  state       <= S_STEP;
                  remaining   <= step_load;
                  stop_reason <= R_NONE;
                  first       <= 1'b1;
               end
            end
            S_RUN, S_STEP: begin
               cycle_count <= cnt_sat;
               first       <= 1'b0;
               if (state == S_STEP) begin
                  remaining <= remaining - STEP_W'(1);
               end
               if (stop) begin
                  state       <= S_IDLE;
                  stop_reason <= R_STOP;
                  done        <= 1'b1;
               end else if (prog_halt) begin
                  state       <= S_HALT;
                  stop_reason <= R_PROG;
                  done        <= 1'b1;
               end else if (bp_hit) begin
                  state       <= S_HALT;
                  stop_reason <= R_BP;
                  done        <= 1'b1;
               end else if (limit_hit) begin
                  state       <= S_HALT;
                  stop_reason <= R_LIMIT;
                  done        <= 1'b1;
               end else if (step_last) begin
                  state       <= S_IDLE;
                  stop_reason <= R_STEP;
                  done        <= 1'b1;
               end
            end
            S_HALT: begin
               if (clear) begin
                  state       <= S_IDLE;
                  stop_reason <= R_NONE;
                  cycle_count <= '0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mic1_exec_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_mic1_exec_ctrl : randomized self-checking bench for mic1_exec_ctrl|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_mic1_exec_ctrl;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       start = 1'b0, step = 1'b0, stop = 1'b0, clear = 1'b0;
   logic       prog_halt = 1'b0, bp_en = 1'b0;
   logic [7:0] step_count = 8'd0;
   logic [8:0] bp_addr = 9'h010;
   logic [8:0] mpc = 9'h000;

   logic        run_a, busy_a, done_a;
   logic [2:0]  reason_a;
   logic [31:0] count_a;
   logic        run_b, busy_b, done_b;
   logic [2:0]  reason_b;
   logic [31:0] count_b;
   logic        run_c, busy_c, done_c;
   logic [2:0]  reason_c;
   logic [2:0]  count_c;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mic1_exec_ctrl dut_a (
      .clk(clk), .resetn(resetn), .start(start), .step(step), .stop(stop), .clear(clear),
      .step_count(step_count), .bp_en(bp_en), .bp_addr(bp_addr), .mpc(mpc),
      .prog_halt(prog_halt), .run(run_a), .busy(busy_a), .done(done_a),
      .stop_reason(reason_a), .cycle_count(count_a)
   );

   mic1_exec_ctrl #(.CYCLE_LIMIT(10)) dut_b (
      .clk(clk), .resetn(resetn), .start(start), .step(step), .stop(stop), .clear(clear),
      .step_count(step_count), .bp_en(bp_en), .bp_addr(bp_addr), .mpc(mpc),
      .prog_halt(prog_halt), .run(run_b), .busy(busy_b), .done(done_b),
      .stop_reason(reason_b), .cycle_count(count_b)
   );

   mic1_exec_ctrl #(.CNT_W(3)) dut_c (
      .clk(clk), .resetn(resetn), .start(start), .step(step), .stop(stop), .clear(clear),
      .step_count(step_count), .bp_en(bp_en), .bp_addr(bp_addr), .mpc(mpc),
      .prog_halt(prog_halt), .run(run_c), .busy(busy_c), .done(done_c),
      .stop_reason(reason_c), .cycle_count(count_c)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      start = 0; step = 0; stop = 0; clear = 0; prog_halt = 0;
      resetn = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
   endtask

   // Rule-level prediction: first busy cycle k at which any exit condition holds.
   function automatic void model(input bit is_step, input int sc, input int stop_at,
                                 input int prog_at, input int bp_at, input bit bpen,
                                 output int n, output logic [2:0] why);
      int steps;
      steps = (sc == 0) ? 1 : sc;
      n = 0;
      why = 3'd0;
      for (int k = 1; k <= 60; k++) begin
         if (k == stop_at)                      why = 3'd1;
         else if (k == prog_at)                 why = 3'd4;
         else if (bpen && k == bp_at && k > 1)  why = 3'd3;
         else if (is_step && k == steps)        why = 3'd2;
         if (why != 3'd0) begin
            n = k;
            break;
         end
      end
   endfunction

   // Launch one run/step on dut_a, drive per-cycle events, report what was seen, then clean up.
   task automatic scenario(input bit is_step, input int sc, input int stop_at, input int prog_at,
                           input int bp_at, output int n, output logic done_exit,
                           output logic [2:0] why, output logic [31:0] cnt, output logic done_next);
      step_count = 8'(sc);
      if (is_step) step = 1'b1;
      else         start = 1'b1;
      tick();
      start = 1'b0;
      step  = 1'b0;
      n = 0;
      for (int k = 1; k <= 60 && run_a; k++) begin
         stop       = (k == stop_at);
         prog_halt  = (k == prog_at);
         mpc        = (k == bp_at) ? bp_addr
                                   : 9'((int'(bp_addr) + 1 + int'($urandom_range(0, 500))) % 512);
         step_count = 8'($urandom);
         tick();
         n++;
      end
      stop = 1'b0;
      prog_halt = 1'b0;
      done_exit = done_a;
      why = reason_a;
      cnt = count_a;
      tick();
      done_next = done_a;
      if (run_a) begin
         stop = 1'b1;
         tick();
         stop = 1'b0;
      end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      start = 1; step = 1; stop = 1; clear = 1; prog_halt = 1; step_count = 8'd5;
      resetn = 1'b0;
      tick();
      tick();
      n_checks++; if (run_a !== 1'b0)   begin n_fail++; $display("FAIL reset_run: got %b want 0", run_a); end
      n_checks++; if (busy_a !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_a); end
      n_checks++; if (done_a !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b want 0", done_a); end
      n_checks++; if (reason_a !== 3'd0) begin n_fail++; $display("FAIL reset_reason: got %0d want 0", reason_a); end
      n_checks++; if (count_a !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count_a); end
      start = 0; step = 0; stop = 0; clear = 0; prog_halt = 0;
      resetn = 1'b1;
      tick();
      n_checks++; if (run_a !== 1'b0)   begin n_fail++; $display("FAIL reset_release_run: got %b want 0", run_a); end
   endtask

   task automatic test_step_count;
      int n; logic de, dn; logic [2:0] why; logic [31:0] cnt;
      bp_en = 1'b0;
      scenario(1'b1, 3, 0, 0, 0, n, de, why, cnt, dn);
      n_checks++; if (n !== 3)       begin n_fail++; $display("FAIL step3_cycles: got %0d want 3", n); end
      n_checks++; if (de !== 1'b1)   begin n_fail++; $display("FAIL step3_done: got %b want 1", de); end
      n_checks++; if (dn !== 1'b0)   begin n_fail++; $display("FAIL step3_done_width: got %b want 0", dn); end
      n_checks++; if (why !== 3'd2)  begin n_fail++; $display("FAIL step3_reason: got %0d want 2", why); end
      n_checks++; if (cnt !== 32'd3) begin n_fail++; $display("FAIL step3_count: got %0d want 3", cnt); end
      scenario(1'b1, 0, 0, 0, 0, n, de, why, cnt, dn);
      n_checks++; if (n !== 1)       begin n_fail++; $display("FAIL step0_cycles: got %0d want 1", n); end
      n_checks++; if (why !== 3'd2)  begin n_fail++; $display("FAIL step0_reason: got %0d want 2", why); end
      n_checks++; if (cnt !== 32'd1) begin n_fail++; $display("FAIL step0_count: got %0d want 1", cnt); end
   endtask

   task automatic test_breakpoint;
      int n; logic de, dn; logic [2:0] why; logic [31:0] cnt;
      bp_en = 1'b1;
      scenario(1'b0, 0, 0, 0, 5, n, de, why, cnt, dn);
      n_checks++; if (n !== 5)       begin n_fail++; $display("FAIL bp_cycles: got %0d want 5", n); end
      n_checks++; if (why !== 3'd3)  begin n_fail++; $display("FAIL bp_reason: got %0d want 3", why); end
      n_checks++; if (cnt !== 32'd5) begin n_fail++; $display("FAIL bp_count: got %0d want 5", cnt); end
      n_checks++; if (count_a !== 32'd0 || run_a !== 1'b0)
         begin n_fail++; $display("FAIL bp_clear: got count %0d run %b want 0 0", count_a, run_a); end
      scenario(1'b0, 0, 4, 0, 1, n, de, why, cnt, dn);
      n_checks++; if (n !== 4)       begin n_fail++; $display("FAIL bp_first_skip_cycles: got %0d want 4", n); end
      n_checks++; if (why !== 3'd1)  begin n_fail++; $display("FAIL bp_first_skip_reason: got %0d want 1", why); end
      bp_en = 1'b0;
   endtask

   task automatic test_priority;
      int n; logic de, dn; logic [2:0] why; logic [31:0] cnt;
      bp_en = 1'b1;
      scenario(1'b0, 0, 3, 3, 3, n, de, why, cnt, dn);
      n_checks++; if (n !== 3 || why !== 3'd1)
         begin n_fail++; $display("FAIL prio_stop: got n=%0d reason=%0d want 3 1", n, why); end
      scenario(1'b1, 6, 0, 2, 2, n, de, why, cnt, dn);
      n_checks++; if (n !== 2 || why !== 3'd4)
         begin n_fail++; $display("FAIL prio_prog: got n=%0d reason=%0d want 2 4", n, why); end
      scenario(1'b1, 4, 0, 0, 4, n, de, why, cnt, dn);
      n_checks++; if (n !== 4 || why !== 3'd3)
         begin n_fail++; $display("FAIL prio_bp_over_step: got n=%0d reason=%0d want 4 3", n, why); end
      bp_en = 1'b0;
   endtask

   task automatic test_hold_and_clear;
      do_reset();
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick(); tick();
      clear = 1'b1; tick(); clear = 1'b0;
      n_checks++; if (count_a !== 32'd4 || run_a !== 1'b1)
         begin n_fail++; $display("FAIL clear_in_run: got count %0d run %b want 4 1", count_a, run_a); end
      stop = 1'b1; tick(); stop = 1'b0;
      n_checks++; if (count_a !== 32'd5 || done_a !== 1'b1 || reason_a !== 3'd1)
         begin n_fail++; $display("FAIL stop_exit: got count %0d done %b reason %0d want 5 1 1", count_a, done_a, reason_a); end
      tick(); tick(); tick();
      n_checks++; if (reason_a !== 3'd1 || done_a !== 1'b0)
         begin n_fail++; $display("FAIL reason_hold: got reason %0d done %b want 1 0", reason_a, done_a); end
      step_count = 8'd2; step = 1'b1; tick(); step = 1'b0;
      n_checks++; if (reason_a !== 3'd0 || run_a !== 1'b1)
         begin n_fail++; $display("FAIL entry_clears_reason: got reason %0d run %b want 0 1", reason_a, run_a); end
      tick(); tick();
      n_checks++; if (reason_a !== 3'd2 || count_a !== 32'd7 || run_a !== 1'b0)
         begin n_fail++; $display("FAIL step2_exit: got reason %0d count %0d run %b want 2 7 0", reason_a, count_a, run_a); end
      start = 1'b1; tick(); start = 1'b0;
      tick();
      prog_halt = 1'b1; tick(); prog_halt = 1'b0;
      n_checks++; if (reason_a !== 3'd4 || count_a !== 32'd9)
         begin n_fail++; $display("FAIL prog_halt: got reason %0d count %0d want 4 9", reason_a, count_a); end
      start = 1'b1; tick(); start = 1'b0;
      step = 1'b1; tick(); step = 1'b0;
      n_checks++; if (run_a !== 1'b0 || reason_a !== 3'd4)
         begin n_fail++; $display("FAIL halt_ignores: got run %b reason %0d want 0 4", run_a, reason_a); end
      clear = 1'b1; tick(); clear = 1'b0;
      n_checks++; if (reason_a !== 3'd0 || count_a !== 32'd0)
         begin n_fail++; $display("FAIL halt_clear: got reason %0d count %0d want 0 0", reason_a, count_a); end
   endtask

   task automatic test_random;
      int n, en; logic de, dn; logic [2:0] why, ewhy; logic [31:0] cnt;
      bit is_step; int sc, sa, pa, ba;
      for (int i = 0; i < 20; i++) begin
         is_step = 1'($urandom_range(0, 1));
         bp_en   = 1'($urandom_range(0, 1));
         sc = $urandom_range(0, 7);
         sa = $urandom_range(0, 15);
         pa = $urandom_range(0, 15);
         ba = $urandom_range(0, 12);
         if (!is_step && sa == 0) sa = 14;
         model(is_step, sc, sa, pa, ba, bp_en, en, ewhy);
         scenario(is_step, sc, sa, pa, ba, n, de, why, cnt, dn);
         n_checks++;
         if (n !== en || why !== ewhy || cnt !== 32'(en) || de !== 1'b1 || dn !== 1'b0) begin
            n_fail++;
            $display("FAIL random_%0d: got n=%0d reason=%0d count=%0d done=%b/%b want n=%0d reason=%0d count=%0d done=1/0",
                     i, n, why, cnt, de, dn, en, ewhy, en);
         end
      end
      bp_en = 1'b0;
   endtask

   task automatic test_limit;
      int n;
      do_reset();
      start = 1'b1; tick(); start = 1'b0;
      n = 0;
      for (int k = 0; k < 40 && run_b; k++) begin
         tick();
         n++;
      end
      n_checks++; if (n !== 10 || reason_b !== 3'd5 || count_b !== 32'd10 || done_b !== 1'b1)
         begin n_fail++; $display("FAIL limit_exit: got n=%0d reason=%0d count=%0d done=%b want 10 5 10 1", n, reason_b, count_b, done_b); end
      start = 1'b1; tick(); start = 1'b0;
      n_checks++; if (run_b !== 1'b0 || reason_b !== 3'd5)
         begin n_fail++; $display("FAIL limit_start_ignored: got run %b reason %0d want 0 5", run_b, reason_b); end
      clear = 1'b1; tick(); clear = 1'b0;
      n_checks++; if (count_b !== 32'd0 || reason_b !== 3'd0)
         begin n_fail++; $display("FAIL limit_clear: got count %0d reason %0d want 0 0", count_b, reason_b); end
      stop = 1'b1; tick(); stop = 1'b0;
   endtask

   task automatic test_saturation;
      do_reset();
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 12; k++) tick();
      n_checks++; if (count_c !== 3'd7 || run_c !== 1'b1)
         begin n_fail++; $display("FAIL saturate: got count %0d run %b want 7 1", count_c, run_c); end
      n_checks++; if (count_a !== 32'd12)
         begin n_fail++; $display("FAIL free_run_count: got %0d want 12", count_a); end
      stop = 1'b1; tick(); stop = 1'b0;
   endtask

   task automatic test_reset_mid_step;
      do_reset();
      step_count = 8'd10; step = 1'b1; tick(); step = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      n_checks++; if (count_a !== 32'd5 || run_a !== 1'b1)
         begin n_fail++; $display("FAIL mid_step_pre: got count %0d run %b want 5 1", count_a, run_a); end
      resetn = 1'b0; tick();
      n_checks++; if (run_a !== 1'b0 || busy_a !== 1'b0 || count_a !== 32'd0 || done_a !== 1'b0)
         begin n_fail++; $display("FAIL mid_step_reset: got run %b busy %b count %0d done %b want 0 0 0 0", run_a, busy_a, count_a, done_a); end
      resetn = 1'b1; tick();
      n_checks++; if (run_a !== 1'b0 || done_a !== 1'b0)
         begin n_fail++; $display("FAIL mid_step_after: got run %b done %b want 0 0", run_a, done_a); end
   endtask

   initial begin
      test_reset();
      test_step_count();
      test_breakpoint();
      test_priority();
      test_hold_and_clear();
      do_reset();
      test_random();
      test_limit();
      test_saturation();
      test_reset_mid_step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mic1_exec_ctrl.md
MIC1_EXEC_CTRL -- requirements
Module: mic1_exec_ctrl

Interface
REQ-001 SHALL have parameter STEP_W, default 8, width of step_count and the remaining-step counter.
REQ-002 SHALL have parameter CNT_W, default 32, width of cycle_count.
REQ-003 SHALL have parameter CYCLE_LIMIT, default 0, run-cycle budget; 0 = disabled.
REQ-004 SHALL have port clk  in  1  single clock; all logic on posedge clk.
REQ-005 SHALL have port resetn  in  1  synchronous, active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse, enter free-run.
REQ-007 SHALL have port step  in  1  one-cycle pulse, run step_count microcycles.
REQ-008 SHALL have port stop  in  1  level, abort RUN/STEP.
REQ-009 SHALL have port clear  in  1  one-cycle pulse, leave HALT and zero cycle_count.
REQ-010 SHALL have port step_count  in  STEP_W  microcycles per step; 0 treated as 1.
REQ-011 SHALL have port bp_en  in  1  breakpoint enable.
REQ-012 SHALL have port bp_addr  in  9  breakpoint microaddress.
REQ-013 SHALL have port mpc  in  9  current MPC of the mic1 core.
REQ-014 SHALL have port prog_halt  in  1  core reports program end.
REQ-015 SHALL have port run  out  1  enable to mic1_soc run input.
REQ-016 SHALL have port busy  out  1  state is RUN or STEP.
REQ-017 SHALL have port done  out  1  one-cycle pulse on exit from RUN/STEP.
REQ-018 SHALL have port stop_reason  out  3  0 none, 1 STOP, 2 STEP_DONE, 3 BP, 4 PROG, 5 LIMIT.
REQ-019 SHALL have port cycle_count  out  CNT_W  number of cycles with run=1.

Function
REQ-020 SHALL implement states IDLE, RUN, STEP, HALT; run = busy = (state is RUN or STEP), decoded from registered state only.
REQ-021 IDLE: start -> RUN; else step -> STEP, loading remaining = max(step_count,1); start wins if both are asserted.
REQ-022 RUN/STEP exit priority per cycle: stop > prog_halt > breakpoint > limit > step exhaustion.
REQ-023 stop in RUN/STEP -> IDLE, stop_reason=1.
REQ-024 prog_halt in RUN/STEP -> HALT, stop_reason=4.
REQ-025 Breakpoint: bp_en && mpc==bp_addr in RUN/STEP -> HALT, stop_reason=3; SHALL be ignored in the first busy cycle after entry from IDLE so the core resumes past the breakpoint.
REQ-026 Limit: CYCLE_LIMIT!=0 and cycle_count+1 == CYCLE_LIMIT on a busy cycle -> HALT, stop_reason=5.
REQ-027 STEP: remaining decrements each busy cycle; at remaining==1 -> IDLE, stop_reason=2; exactly max(step_count,1) run cycles.
REQ-028 Cycle that triggers an exit still has run=1 and is counted; run is 0 from the next cycle.
REQ-029 done SHALL pulse for exactly one cycle, the first cycle after any RUN/STEP exit.
REQ-030 HALT: run=0; start, step and stop ignored; clear -> IDLE, stop_reason=0, cycle_count=0.
REQ-031 clear in IDLE SHALL zero cycle_count and stop_reason; clear in RUN/STEP ignored.
REQ-032 cycle_count SHALL increment by 1 on each busy cycle and saturate at all-ones (no wrap).
REQ-033 step_count changes while in STEP SHALL not affect remaining.
REQ-034 stop_reason SHALL hold its value until the next exit, clear, or reset; entering RUN/STEP SHALL set it to 0.

Reset
REQ-035 resetn=0 at posedge clk SHALL force state=IDLE, run=0, busy=0, done=0, stop_reason=0, cycle_count=0, remaining=0, first-cycle flag set, from any state including mid-RUN/STEP.
REQ-036 Inputs SHALL be ignored while resetn=0; no done pulse from a reset-induced exit.

Verification
REQ-037 step_count=3, step pulse in IDLE -> run high exactly 3 cycles, done 1 cycle after, stop_reason=2, cycle_count=3.
REQ-038 step_count=0, step pulse -> run high 1 cycle, stop_reason=2, cycle_count=1.
REQ-039 bp_en=1, bp_addr=0x010, start, mpc hits 0x010 on 5th run cycle -> HALT, stop_reason=3, cycle_count=5; clear -> IDLE, count 0; start with mpc=0x010 in first cycle -> no halt on that cycle.
REQ-040 CYCLE_LIMIT=10, start -> exactly 10 run cycles, HALT, stop_reason=5, start ignored until clear.
REQ-041 Same cycle stop=1, prog_halt=1, breakpoint match -> IDLE, stop_reason=1.
REQ-042 resetn=0 during STEP with remaining=5 -> next cycle run=0, state IDLE, cycle_count=0, done=0.
